// File: rtl/l2_arbiter.sv
// Round-robin arbiter sharing the L2 port between the L1 I-cache and D-cache miss paths.
// Command/address/data are muxed from the granted side; the L2 response is routed back to it only.
module l2_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_addr,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp,
  output logic [CNT_W-1:0]  i_served,
  output logic [CNT_W-1:0]  d_served
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RELEASE} state_t;

  state_t state, state_nx;
  logic   last_d, last_d_nx;
  logic   i_pend, d_pend;

  assign i_pend = i_read;
  assign d_pend = d_read | d_write;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      last_d   <= 1'b1;
      i_served <= '0;
      d_served <= '0;
    end else begin
      state  <= state_nx;
      last_d <= last_d_nx;
      if (state == SERVE_I && l2_resp) i_served <= i_served + CNT_W'(1);
      if (state == SERVE_D && l2_resp) d_served <= d_served + CNT_W'(1);
    end
  end

  always_comb begin
    state_nx  = state;
    last_d_nx = last_d;
    l2_read   = 1'b0;
    l2_write  = 1'b0;
    l2_addr   = '0;
    l2_wdata  = '0;
    i_resp    = 1'b0;
    d_resp    = 1'b0;
    i_rdata   = '0;
    d_rdata   = '0;
    case (state)
      IDLE: begin
        // With both pending, the side not granted last time wins.
        if (i_pend && (!d_pend || last_d)) begin
          state_nx  = SERVE_I;
          last_d_nx = 1'b0;
        end else if (d_pend) begin
          state_nx  = SERVE_D;
          last_d_nx = 1'b1;
        end
      end
      SERVE_I: begin
        l2_read = i_read;
        l2_addr = i_addr;
        i_resp  = l2_resp;
        i_rdata = l2_rdata;
        if (l2_resp) state_nx = RELEASE;
      end
      SERVE_D: begin
        // A simultaneous read+write from the D side is forwarded as a write only.
        l2_read  = d_read & ~d_write;
        l2_write = d_write;
        l2_addr  = d_addr;
        l2_wdata = d_wdata;
        d_resp   = l2_resp;
        d_rdata  = l2_rdata;
        if (l2_resp) state_nx = RELEASE;
      end
      RELEASE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_l2_arbiter.sv
// Self-checking bench for l2_arbiter: directed scenarios plus randomized rounds against a
// transaction-level model (grant order, counters, routing) kept in the bench.
module tb_l2_arbiter;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_read, d_read, d_write, l2_resp;
  logic [ADDR_W-1:0] i_addr, d_addr;
  logic [LINE_W-1:0] d_wdata, l2_rdata;
  logic [LINE_W-1:0] i_rdata, d_rdata, l2_wdata;
  logic              i_resp, d_resp, l2_read, l2_write;
  logic [ADDR_W-1:0] l2_addr;
  logic [CNT_W-1:0]  i_served, d_served;

  int checks = 0;
  int errors = 0;
  int m_i_cnt, m_d_cnt;
  bit m_last_d;

  always #5 clk = ~clk;

  l2_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .l2_read(l2_read), .l2_write(l2_write), .l2_addr(l2_addr), .l2_wdata(l2_wdata),
    .l2_rdata(l2_rdata), .l2_resp(l2_resp),
    .i_served(i_served), .d_served(d_served)
  );

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] v;
    for (int k = 0; k < LINE_W / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic clear_inputs();
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; l2_resp = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; l2_rdata = '0;
  endtask

  // Returns at a negedge with reset released and the arbiter idle.
  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    m_i_cnt = 0; m_d_cnt = 0; m_last_d = 1'b1;
  endtask

  // One arbitration round starting in IDLE. mode: 0 random, 1 both, 2 D only, 3 I only, 4 D read+write.
  task automatic run_round(input int mode, input int lat_in, input logic [LINE_W-1:0] rd_in,
                           input bit use_rd, output bit side_d);
    bit exp_d;
    int lat;
    logic exp_rd, exp_wr;
    logic [ADDR_W-1:0] exp_addr;
    logic [LINE_W-1:0] exp_wd, rd;
    logic [CNT_W-1:0] ei, ed;
    if (!i_read && (mode == 1 || mode == 3 || (mode == 0 && $urandom_range(1, 0) == 1))) begin
      i_read = 1'b1; i_addr = $urandom & 32'hFFFF_FFE0;
    end
    if (!d_read && !d_write && (mode == 1 || mode == 2 || mode == 4 ||
                                (mode == 0 && $urandom_range(1, 0) == 1))) begin
      d_addr = $urandom & 32'hFFFF_FFE0; d_wdata = rand_line();
      if (mode == 4) begin d_read = 1'b1; d_write = 1'b1; end
      else case ($urandom_range(2, 0))
        0: d_read = 1'b1;
        1: d_write = 1'b1;
        default: begin d_read = 1'b1; d_write = 1'b1; end
      endcase
    end
    if (!i_read && !d_read && !d_write) begin
      i_read = 1'b1; i_addr = $urandom & 32'hFFFF_FFE0;
    end
    exp_d    = (d_read || d_write) && (!i_read || !m_last_d);
    exp_rd   = exp_d ? (d_read && !d_write) : 1'b1;
    exp_wr   = exp_d ? d_write : 1'b0;
    exp_addr = exp_d ? d_addr : i_addr;
    exp_wd   = exp_d ? d_wdata : '0;
    #1;
    checks++;
    if (l2_read !== 1'b0 || l2_write !== 1'b0 || i_resp !== 1'b0 || d_resp !== 1'b0) begin
      errors++;
      $display("FAIL idle_quiet: l2_read=%b l2_write=%b i_resp=%b d_resp=%b, want all 0",
               l2_read, l2_write, i_resp, d_resp);
    end
    @(negedge clk); #1;
    checks++;
    if ({l2_read, l2_write} !== {exp_rd, exp_wr} || l2_addr !== exp_addr) begin
      errors++;
      $display("FAIL grant_cmd: rd/wr=%b%b addr=%h, want %b%b addr=%h",
               l2_read, l2_write, l2_addr, exp_rd, exp_wr, exp_addr);
    end
    checks++;
    if (l2_wdata !== exp_wd) begin
      errors++;
      $display("FAIL grant_wdata: got %h want %h", l2_wdata, exp_wd);
    end
    lat = (lat_in < 0) ? $urandom_range(3, 0) : lat_in;
    for (int k = 0; k < lat; k++) begin
      @(negedge clk); #1;
      checks++;
      if (l2_addr !== exp_addr || i_resp !== 1'b0 || d_resp !== 1'b0) begin
        errors++;
        $display("FAIL hold_grant: addr=%h i_resp=%b d_resp=%b, want addr=%h no resp",
                 l2_addr, i_resp, d_resp, exp_addr);
      end
    end
    rd = use_rd ? rd_in : rand_line();
    l2_rdata = rd; l2_resp = 1'b1;
    #1;
    checks++;
    if (exp_d ? (d_resp !== 1'b1 || i_resp !== 1'b0 || d_rdata !== rd || i_rdata !== '0)
              : (i_resp !== 1'b1 || d_resp !== 1'b0 || i_rdata !== rd || d_rdata !== '0)) begin
      errors++;
      $display("FAIL resp_route: i_resp=%b d_resp=%b i_rdata_ok=%b d_rdata_ok=%b, want side_d=%b",
               i_resp, d_resp, i_rdata === (exp_d ? '0 : rd), d_rdata === (exp_d ? rd : '0), exp_d);
    end
    if (exp_d) m_d_cnt++; else m_i_cnt++;
    m_last_d = exp_d;
    ei = m_i_cnt[CNT_W-1:0];
    ed = m_d_cnt[CNT_W-1:0];
    @(negedge clk);
    l2_resp = 1'b0; l2_rdata = rand_line();
    if (exp_d) begin d_read = 1'b0; d_write = 1'b0; end
    else i_read = 1'b0;
    #1;
    checks++;
    if (l2_read !== 1'b0 || l2_write !== 1'b0 || i_resp !== 1'b0 || d_resp !== 1'b0 ||
        i_rdata !== '0 || d_rdata !== '0) begin
      errors++;
      $display("FAIL release_quiet: l2_read=%b l2_write=%b i_resp=%b d_resp=%b, want all 0",
               l2_read, l2_write, i_resp, d_resp);
    end
    checks++;
    if (i_served !== ei || d_served !== ed) begin
      errors++;
      $display("FAIL counters: i_served=%0d d_served=%0d, want %0d %0d", i_served, d_served, ei, ed);
    end
    @(negedge clk);
    side_d = exp_d;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    i_read = 1'b1; d_write = 1'b1; l2_resp = 1'b1; l2_rdata = rand_line();
    i_addr = 32'hDEAD_BEE0; d_addr = 32'hCAFE_0000; d_wdata = rand_line();
    @(negedge clk); #1;
    checks++;
    if (l2_read !== 1'b0 || l2_write !== 1'b0 || l2_addr !== '0 || l2_wdata !== '0 ||
        i_resp !== 1'b0 || d_resp !== 1'b0 || i_rdata !== '0 || d_rdata !== '0) begin
      errors++;
      $display("FAIL reset_outputs: l2_read=%b l2_write=%b l2_addr=%h i_resp=%b d_resp=%b, want 0",
               l2_read, l2_write, l2_addr, i_resp, d_resp);
    end
    checks++;
    if (i_served !== '0 || d_served !== '0) begin
      errors++;
      $display("FAIL reset_counters: i_served=%0d d_served=%0d, want 0 0", i_served, d_served);
    end
    do_reset();
  endtask

  task automatic test_single_read();
    bit s;
    logic [LINE_W-1:0] a5;
    a5 = {(LINE_W/8){8'hA5}};
    do_reset();
    i_read = 1'b1; i_addr = 32'h0000_1000;
    run_round(3, 4, a5, 1'b1, s);
    checks++;
    if (s !== 1'b0 || i_served !== 4'd1) begin
      errors++;
      $display("FAIL single_read: side_d=%b i_served=%0d, want 0 1", s, i_served);
    end
  endtask

  task automatic test_single_write();
    bit s;
    do_reset();
    d_write = 1'b1; d_addr = 32'h0000_2040; d_wdata = {(LINE_W/32){32'h1234_5678}};
    run_round(2, 2, '0, 1'b0, s);
    checks++;
    if (s !== 1'b1 || d_served !== 4'd1 || i_served !== 4'd0) begin
      errors++;
      $display("FAIL single_write: side_d=%b d_served=%0d i_served=%0d, want 1 1 0",
               s, d_served, i_served);
    end
  endtask

  task automatic test_back_to_back();
    bit s;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      run_round(1, -1, '0, 1'b0, s);
      checks++;
      if (s !== k[0]) begin
        errors++;
        $display("FAIL rr_order: round %0d granted side_d=%b, want %b", k, s, k[0]);
      end
    end
  endtask

  task automatic test_wait();
    logic [LINE_W-1:0] rl;
    do_reset();
    i_read = 1'b1; i_addr = 32'h0000_3000;
    @(negedge clk); #1;
    d_read = 1'b1; d_addr = 32'h0000_4080;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if (l2_read !== 1'b1 || l2_addr !== i_addr || d_resp !== 1'b0) begin
        errors++;
        $display("FAIL wait_hold: l2_read=%b l2_addr=%h d_resp=%b, want 1 %h 0",
                 l2_read, l2_addr, d_resp, i_addr);
      end
      @(negedge clk);
    end
    rl = rand_line();
    l2_rdata = rl; l2_resp = 1'b1; #1;
    checks++;
    if (i_resp !== 1'b1 || d_resp !== 1'b0 || i_rdata !== rl) begin
      errors++;
      $display("FAIL wait_iresp: i_resp=%b d_resp=%b, want 1 0", i_resp, d_resp);
    end
    m_i_cnt++; m_last_d = 1'b0;
    @(negedge clk); l2_resp = 1'b0; i_read = 1'b0; #1;
    checks++;
    if (l2_read !== 1'b0 || l2_addr !== '0) begin
      errors++;
      $display("FAIL wait_release: l2_read=%b l2_addr=%h, want 0 0", l2_read, l2_addr);
    end
    @(negedge clk); #1;
    checks++;
    if (l2_read !== 1'b0 || l2_addr !== '0 || d_resp !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle: l2_read=%b l2_addr=%h d_resp=%b, want 0 0 0", l2_read, l2_addr, d_resp);
    end
    @(negedge clk); #1;
    checks++;
    if (l2_read !== 1'b1 || l2_addr !== d_addr) begin
      errors++;
      $display("FAIL wait_dgrant: l2_read=%b l2_addr=%h, want 1 %h", l2_read, l2_addr, d_addr);
    end
    m_last_d = 1'b1;
    l2_resp = 1'b1; #1;
    checks++;
    if (d_resp !== 1'b1 || i_resp !== 1'b0) begin
      errors++;
      $display("FAIL wait_dresp: d_resp=%b i_resp=%b, want 1 0", d_resp, i_resp);
    end
    m_d_cnt++;
    @(negedge clk); l2_resp = 1'b0; d_read = 1'b0; #1;
    checks++;
    if (i_served !== 4'd1 || d_served !== 4'd1) begin
      errors++;
      $display("FAIL wait_counts: i_served=%0d d_served=%0d, want 1 1", i_served, d_served);
    end
    @(negedge clk);
  endtask

  task automatic test_illegal_and_wrap();
    bit s;
    do_reset();
    for (int k = 0; k < 3; k++) run_round(4, -1, '0, 1'b0, s);
    for (int k = 0; k < 12; k++) run_round(2, -1, '0, 1'b0, s);
    checks++;
    if (d_served !== 4'hF) begin
      errors++;
      $display("FAIL wrap_max: d_served=%0d, want 15", d_served);
    end
    run_round(2, -1, '0, 1'b0, s);
    checks++;
    if (d_served !== 4'h0) begin
      errors++;
      $display("FAIL wrap_zero: d_served=%0d, want 0", d_served);
    end
  endtask

  task automatic test_random();
    bit s;
    for (int k = 0; k < 60; k++) run_round(0, -1, '0, 1'b0, s);
  endtask

  task automatic test_async_reset();
    bit s;
    i_read = 1'b0; d_read = 1'b1; d_write = 1'b0; d_addr = 32'h0000_5520;
    @(negedge clk); #1;
    checks++;
    if (l2_read !== 1'b1 || l2_addr !== d_addr) begin
      errors++;
      $display("FAIL areset_pre: l2_read=%b l2_addr=%h, want 1 %h", l2_read, l2_addr, d_addr);
    end
    #1;
    rst = 1'b0; l2_resp = 1'b1;
    #1;
    checks++;
    if (l2_read !== 1'b0 || l2_write !== 1'b0 || l2_addr !== '0 || d_resp !== 1'b0 ||
        d_rdata !== '0 || i_served !== '0 || d_served !== '0) begin
      errors++;
      $display("FAIL areset_mid: l2_read=%b l2_addr=%h d_resp=%b i_served=%0d d_served=%0d, want 0",
               l2_read, l2_addr, d_resp, i_served, d_served);
    end
    clear_inputs();
    m_i_cnt = 0; m_d_cnt = 0; m_last_d = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    run_round(1, -1, '0, 1'b0, s);
    checks++;
    if (s !== 1'b0) begin
      errors++;
      $display("FAIL areset_regrant: side_d=%b, want 0", s);
    end
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    m_i_cnt = 0; m_d_cnt = 0; m_last_d = 1'b1;
    test_reset();
    test_single_read();
    test_single_write();
    test_back_to_back();
    test_wait();
    test_illegal_and_wrap();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
